// File: rtl/gray2bin_seq_pkg.sv
// Shared types and helpers for the sequential Gray-to-binary decoder.
// The functions are generic up to 32 bits; callers pass the active width.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 32;

    function automatic logic [MAX_WIDTH-1:0] width_mask(input int width);
        logic [MAX_WIDTH-1:0] m;
        if (width >= MAX_WIDTH) m = '1;
        else                    m = (32'd1 << width) - 32'd1;
        return m;
    endfunction

    // Binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g,
                                                      input int width);
        logic [MAX_WIDTH-1:0] gm;
        logic [MAX_WIDTH-1:0] b;
        gm = g & width_mask(width);
        b  = gm;
        for (int k = 1; k < MAX_WIDTH; k++) b = b ^ (gm >> k);
        return b;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b,
                                                      input int width);
        logic [MAX_WIDTH-1:0] bm;
        bm = b & width_mask(width);
        return bm ^ (bm >> 1);
    endfunction

endpackage

// File: rtl/gray2bin_seq_if.sv
// Handshake bundle between a Gray-word producer and the decoder.
interface gray2bin_seq_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] bin_out;
    logic             step_err;

    modport slave (
        input  in_valid, gray_in, out_ready,
        output in_ready, out_valid, bin_out, step_err
    );

    modport master (
        output in_valid, gray_in, out_ready,
        input  in_ready, out_valid, bin_out, step_err
    );
endinterface

// File: rtl/gray2bin_seq_step_chk.sv
// Remembers the last delivered result and flags a new result that is neither
// a repeat nor a single +1 step (mod 2^WIDTH) from it.
module gray_step_chk #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] result,
    input  logic             deliver,
    input  logic [WIDTH-1:0] delivered,
    output logic             err
);
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_inc;
    logic             prev_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (deliver) begin
            prev       <= delivered;
            prev_valid <= 1'b1;
        end
    end

    assign prev_inc = prev + 1'b1;
    assign err      = prev_valid && (result != prev) && (result != prev_inc);
endmodule

// File: rtl/gray2bin_seq.sv
// Sequential Gray-to-binary decoder: resolves one bit per cycle MSB-first and
// presents the result on a valid/ready output, with optional step checking.
module gray2bin_seq
    import gray_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int CHECK_STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    gray2bin_seq_if.slave bus,
    output logic          busy
);
    localparam int IW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] bin_q;
    logic             carry, bit_nxt;
    logic             err_q, chk_err;
    logic             accept, deliver, last_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        deliver   = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (idx == '0) begin
                    last_bit  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    deliver   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // carry holds the binary bit just resolved one position above idx.
    assign bit_nxt = gray_q[idx] ^ carry;

    always_comb begin
        acc_nxt      = acc;
        acc_nxt[idx] = bit_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx    <= '0;
            gray_q <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            bin_q  <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            gray_q <= bus.gray_in;
            idx    <= IW'(WIDTH - 1);
            acc    <= '0;
            carry  <= 1'b0;
        end else if (state == SHIFT) begin
            acc   <= acc_nxt;
            carry <= bit_nxt;
            idx   <= idx - 1'b1;
            if (last_bit) begin
                bin_q <= acc_nxt;
                err_q <= chk_err;
            end
        end else if (deliver) begin
            err_q <= 1'b0;
        end
    end

    generate
        if (CHECK_STEP != 0) begin : g_chk
            gray_step_chk #(.WIDTH(WIDTH)) u_chk (
                .clk       (clk),
                .rst_n     (rst_n),
                .result    (acc_nxt),
                .deliver   (deliver),
                .delivered (bin_q),
                .err       (chk_err)
            );
        end else begin : g_no_chk
            assign chk_err = 1'b0;
        end
    endgenerate

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == HOLD);
    assign bus.bin_out   = bin_q;
    assign bus.step_err  = err_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_gray2bin_seq.sv
// Scoreboard bench for gray2bin_seq: a 4-bit instance for directed cases and
// an 8-bit instance for the wide vector plus a long random run.
module tb_gray2bin_seq;
    import gray_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4_n, rst8_n, busy4, busy8;
    int   rdy8_mode = 0;

    gray2bin_seq_if #(.WIDTH(4)) if4 ();
    gray2bin_seq_if #(.WIDTH(8)) if8 ();

    gray2bin_seq #(.WIDTH(4), .CHECK_STEP(1)) u4 (
        .clk(clk), .rst_n(rst4_n), .bus(if4), .busy(busy4));
    gray2bin_seq #(.WIDTH(8), .CHECK_STEP(1)) u8 (
        .clk(clk), .rst_n(rst8_n), .bus(if8), .busy(busy8));

    int         pass_cnt = 0;
    int         total    = 0;
    logic [4:0] q4[$];
    logic [8:0] q8[$];
    logic [7:0] prev8;
    logic       prev8_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s: condition not met at %0t", name, $time);
    endtask

    // Monitors: pop an expectation on every output handshake.
    always @(negedge clk) begin
        if (rst4_n && if4.out_valid && if4.out_ready) begin
            if (q4.size() == 0) fail("out4_unexpected");
            else begin
                logic [4:0] e;
                e = q4.pop_front();
                chk("bin4", {28'd0, if4.bin_out}, {28'd0, e[3:0]});
                chk("step4", {31'd0, if4.step_err}, {31'd0, e[4]});
            end
        end
    end

    always @(negedge clk) begin
        if (rst8_n && if8.out_valid && if8.out_ready) begin
            if (q8.size() == 0) fail("out8_unexpected");
            else begin
                logic [8:0] e;
                e = q8.pop_front();
                chk("bin8", {24'd0, if8.bin_out}, {24'd0, e[7:0]});
                chk("step8", {31'd0, if8.step_err}, {31'd0, e[8]});
            end
        end
    end

    // Sole driver of if8.out_ready.
    initial begin
        if8.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy8_mode)
                0:       if8.out_ready = 1'b0;
                1:       if8.out_ready = 1'b1;
                default: if8.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send4(input logic [3:0] g, input logic [3:0] b, input logic s,
                         input bit push, output time t);
        int n = 0;
        @(negedge clk);
        while (!if4.in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail("send4_timeout");
        if4.in_valid = 1'b1;
        if4.gray_in  = g;
        @(posedge clk);
        t = $time;
        #1 if4.in_valid = 1'b0;
        if (push) q4.push_back({s, b});
    endtask

    task automatic send8(input logic [7:0] g, input logic [7:0] b, input logic s, output time t);
        int n = 0;
        @(negedge clk);
        while (!if8.in_ready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) fail("send8_timeout");
        if8.in_valid = 1'b1;
        if8.gray_in  = g;
        @(posedge clk);
        t = $time;
        #1 if8.in_valid = 1'b0;
        q8.push_back({s, b});
    endtask

    task automatic drain4();
        int n = 0;
        while (q4.size() != 0 && n < 500) begin @(negedge clk); n++; end
        if (q4.size() != 0) fail("drain4_timeout");
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 5000) begin @(negedge clk); n++; end
        if (q8.size() != 0) fail("drain8_timeout");
    endtask

    task automatic reset4();
        @(posedge clk);
        #1 rst4_n = 1'b0;
        @(posedge clk);
        #1 rst4_n = 1'b1;
    endtask

    logic [3:0] gseq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                              4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

    task automatic run4();
        time t, tprev;
        int  n;
        rst4_n = 1'b0; if4.in_valid = 1'b0; if4.gray_in = '0; if4.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst4_in_ready", {31'd0, if4.in_ready}, 32'd1);
        chk("rst4_out_valid", {31'd0, if4.out_valid}, 32'd0);
        chk("rst4_bin", {28'd0, if4.bin_out}, 32'd0);
        chk("rst4_step", {31'd0, if4.step_err}, 32'd0);
        chk("rst4_busy", {31'd0, busy4}, 32'd0);
        rst4_n = 1'b1;

        // Latency: out_valid exactly on the 4th edge after acceptance.
        send4(4'b0110, 4'b0100, 1'b0, 1'b1, t);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk("lat4_in_ready", {31'd0, if4.in_ready}, 32'd0);
            chk("lat4_busy", {31'd0, busy4}, 32'd1);
            chk("lat4_out_valid", {31'd0, if4.out_valid}, {31'd0, k == 4});
        end
        if4.out_ready = 1'b1;
        drain4();

        // Full Gray cycle including wrap, one result per 6 cycles.
        reset4();
        for (int i = 0; i <= 16; i++) begin
            logic [3:0] ix;
            ix = i[3:0];
            send4(gseq[ix], ix, 1'b0, 1'b1, t);
            if (i > 0) chk("period4", 32'(t - tprev), 32'd60);
            tprev = t;
        end
        drain4();

        // Non-monotonic jump, then a repeat.
        reset4();
        send4(4'b0010, 4'b0011, 1'b0, 1'b1, t);
        send4(4'b0111, 4'b0101, 1'b1, 1'b1, t);
        send4(4'b0111, 4'b0101, 1'b0, 1'b1, t);
        drain4();

        // Backpressure: prev=0101, result 0100 is an error and must hold.
        @(posedge clk);
        #1 if4.out_ready = 1'b0;
        send4(4'b0110, 4'b0100, 1'b1, 1'b1, t);
        n = 0;
        while (!if4.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        if (!if4.out_valid) fail("bp4_no_valid");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if4.in_valid = ~if4.in_valid;
            if4.gray_in  = 4'($urandom);
            @(posedge clk);
            #1;
            chk("bp4_out_valid", {31'd0, if4.out_valid}, 32'd1);
            chk("bp4_bin", {28'd0, if4.bin_out}, 32'd4);
            chk("bp4_step", {31'd0, if4.step_err}, 32'd1);
            chk("bp4_in_ready", {31'd0, if4.in_ready}, 32'd0);
        end
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp4_idle_ready", {31'd0, if4.in_ready}, 32'd1);
        chk("bp4_idle_busy", {31'd0, busy4}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1 chk("bp4_no_capture", {31'd0, busy4}, 32'd0);
        end

        // Reset during the second SHIFT cycle aborts the word and clears prev.
        send4(4'b0110, 4'b0000, 1'b0, 1'b0, t);
        @(posedge clk);
        #1 rst4_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", {31'd0, if4.out_valid}, 32'd0);
        chk("mid_rst_bin", {28'd0, if4.bin_out}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy4}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, if4.in_ready}, 32'd1);
        rst4_n = 1'b1;
        send4(4'b1000, 4'b1111, 1'b0, 1'b1, t);
        drain4();
    endtask

    task automatic run8();
        time t;
        rst8_n = 1'b0; if8.in_valid = 1'b0; if8.gray_in = '0; rdy8_mode = 0;
        prev8 = '0; prev8_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst8_in_ready", {31'd0, if8.in_ready}, 32'd1);
        chk("rst8_out_valid", {31'd0, if8.out_valid}, 32'd0);
        rst8_n = 1'b1;

        send8(8'hFF, 8'hAA, 1'b0, t);
        prev8 = 8'hAA; prev8_v = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            chk("lat8_out_valid", {31'd0, if8.out_valid}, {31'd0, k == 8});
        end
        rdy8_mode = 1;
        drain8();

        rdy8_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] gw, bw;
            logic [7:0]  b, pi;
            logic        s;
            pi = prev8 + 8'd1;
            case ($urandom_range(0, 3))
                0:       gw = bin2gray({24'd0, pi}, 8);
                1:       gw = bin2gray({24'd0, prev8}, 8);
                default: gw = $urandom;
            endcase
            bw = gray2bin(gw, 8);
            b  = bw[7:0];
            s  = prev8_v && (b != prev8) && (b != pi);
            send8(gw[7:0], b, s, t);
            prev8   = b;
            prev8_v = 1'b1;
        end
        rdy8_mode = 1;
        drain8();
    endtask

    initial begin
        fork
            run4();
            run8();
        join
        repeat (5) @(posedge clk);
        chk("q4_empty", q4.size(), 32'd0);
        chk("q8_empty", q8.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #3_000_000;
        fail("global_timeout");
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
